// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM responder: opcodes, FSM state encoding
// and the address-width helper.
package spi_ram_pkg;

  localparam logic [7:0] OpWrite = 8'h02;
  localparam logic [7:0] OpRead  = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRead,
    StWrite,
    StIgnore
  } state_e;

  // Number of address bits kept for an array of the given byte depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_ram_responder_if.sv
// SPI pin bundle between an initiator (master) and the RAM responder (slave).
//   spi_clk, spi_cs_n, spi_mosi : initiator -> responder
//   spi_miso, miso_oe           : responder -> initiator
interface spi_ram_responder_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic miso_oe;

  modport master (
    output spi_clk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  miso_oe
  );

  modport slave (
    input  spi_clk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-clk pulses on synchronized edges
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  // Edges are suppressed until the chain and prev_q hold real samples, so a
  // line already at its non-reset level after reset does not look like an edge.
  logic [Stages:0]   fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], din};
      prev_q <= sync_q[Stages-1];
      fill_q <= {fill_q[Stages-1:0], 1'b1};
    end
  end

  assign level = sync_q[Stages-1];
  assign rise  = fill_q[Stages] & level & ~prev_q;
  assign fall  = fill_q[Stages] & ~level & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 byte-addressed RAM responder.
// Opcode 0x02 writes, 0x03 reads, each followed by a 24-bit address (low
// log2(DEPTH) bits kept) and streaming data with wrapping auto-increment.
//   clk, rst_n : system clock, async active-low reset
//   spi        : SPI pins (slave modport)
//   busy       : synchronized chip select is active
//   byte_wr    : one-clk pulse per committed write byte
//   cmd_err    : one-clk pulse when an unsupported opcode completes
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_ram_responder_if.slave   spi,
  output logic                 busy,
  output logic                 byte_wr,
  output logic                 cmd_err
);

  localparam int unsigned AW = addr_width(DEPTH);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi.spi_clk),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi.spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, cs_rise};

  // MOSI uses the same depth as SCK so the sampled bit lines up with sck_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [6:0]      shift_in_q, shift_in_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      tx_q, tx_d;
  logic            oe_q, oe_d;
  logic            load_pend_q, load_pend_d;
  logic            byte_wr_q, byte_wr_d;
  logic            cmd_err_q, cmd_err_d;
  logic            mem_we;
  logic [7:0]      rx_byte;
  logic [7:0]      mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_in_q  <= '0;
      opcode_q    <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      load_pend_q <= 1'b0;
      byte_wr_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_in_q  <= shift_in_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      load_pend_q <= load_pend_d;
      byte_wr_q   <= byte_wr_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= rx_byte;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_in_d  = shift_in_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    oe_d        = oe_q;
    load_pend_d = load_pend_q;
    byte_wr_d   = 1'b0;
    cmd_err_d   = 1'b0;
    mem_we      = 1'b0;
    rx_byte     = {shift_in_q, mosi_s};

    unique case (state_q)
      StIdle: begin
        oe_d = 1'b0;
        tx_d = '0;
        if (cs_fall) begin
          state_d    = StCmd;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      StCmd: begin
        if (sck_rise) begin
          shift_in_d = rx_byte[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            opcode_d = rx_byte;
            if (rx_byte == OpRead || rx_byte == OpWrite) begin
              state_d    = StAddr;
              byte_cnt_d = '0;
            end else begin
              state_d   = StIgnore;
              cmd_err_d = 1'b1;
            end
          end
        end
      end
      StAddr: begin
        if (sck_rise) begin
          // Shifting through an AW-bit register drops the upper address bits.
          addr_d    = {addr_q[AW-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd2) begin
              if (opcode_q == OpRead) begin
                state_d     = StRead;
                load_pend_d = 1'b1;
              end else begin
                state_d = StWrite;
              end
            end
          end
        end
      end
      StRead: begin
        if (sck_fall) begin
          if (load_pend_q) begin
            tx_d        = mem_q[addr_q];
            load_pend_d = 1'b0;
            oe_d        = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d      = addr_q + AW'(1);
            load_pend_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (sck_rise) begin
          shift_in_d = rx_byte[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mem_we    = 1'b1;
            byte_wr_d = 1'b1;
            addr_d    = addr_q + AW'(1);
          end
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    // Deselect wins over everything: drop any partial byte and release MISO.
    if (cs_level && state_q != StIdle) begin
      state_d     = StIdle;
      oe_d        = 1'b0;
      tx_d        = '0;
      load_pend_d = 1'b0;
      mem_we      = 1'b0;
      byte_wr_d   = 1'b0;
      cmd_err_d   = 1'b0;
    end
  end

  assign spi.spi_miso = oe_q ? tx_q[7] : 1'b0;
  assign spi.miso_oe  = oe_q;
  assign busy         = ~cs_level;
  assign byte_wr      = byte_wr_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
module tb_spi_ram_responder;

  localparam int Half = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, byte_wr, cmd_err;

  spi_ram_responder_if bus ();

  spi_ram_responder #(
    .DEPTH       (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (bus),
    .busy    (busy),
    .byte_wr (byte_wr),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (byte_wr) wr_cnt++;
    if (cmd_err) err_cnt++;
    if (bus.miso_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode 0: drive MOSI while SCK low, sample MISO just before the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      #Half;
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      #Half;
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    #(2 * Half);
  endtask

  task automatic cs_high();
    #Half;
    bus.spi_cs_n = 1'b1;
    #(4 * Half);
  endtask

  task automatic header(input logic [7:0] op, input logic [23:0] addr);
    logic [7:0] d;
    spi_bits(op, 8, d);
    spi_bits(addr[23:16], 8, d);
    spi_bits(addr[15:8], 8, d);
    spi_bits(addr[7:0], 8, d);
  endtask

  task automatic write_txn(input logic [23:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                           input int n);
    logic [7:0] d;
    cs_low();
    header(8'h02, addr);
    spi_bits(d0, 8, d);
    if (n > 1) spi_bits(d1, 8, d);
    cs_high();
  endtask

  task automatic read2(input logic [23:0] addr, output logic [7:0] r0, output logic [7:0] r1);
    cs_low();
    header(8'h03, addr);
    spi_bits(8'h00, 8, r0);
    spi_bits(8'h00, 8, r1);
    cs_high();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1, d;
    int wr0, err0, oe0, lat;

    bus.spi_clk  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    check("rst_busy", busy, 0);
    check("rst_byte_wr", byte_wr, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_miso", bus.spi_miso, 0);
    check("rst_oe", bus.miso_oe, 0);
    rst_n = 1'b1;
    #100;

    // Two-byte write then read-back.
    wr0 = wr_cnt;
    write_txn(24'h000010, 8'hA5, 8'h5A, 2);
    check("wr2_byte_wr", wr_cnt - wr0, 2);
    read2(24'h000010, r0, r1);
    check("rd_10", r0, 8'hA5);
    check("rd_11", r1, 8'h5A);
    check("idle_oe", bus.miso_oe, 0);
    check("idle_miso", bus.spi_miso, 0);

    // Address wrap 63 -> 0.
    write_txn(24'h00003F, 8'h11, 8'h22, 2);
    read2(24'h00003F, r0, r1);
    check("rd_3f", r0, 8'h11);
    check("rd_wrap_00", r1, 8'h22);
    read2(24'h000000, r0, r1);
    check("rd_00", r0, 8'h22);

    // Unsupported opcode with trailing clocks.
    wr0 = wr_cnt; err0 = err_cnt; oe0 = oe_cnt;
    cs_low();
    spi_bits(8'h9F, 8, d);
    for (int i = 0; i < 4; i++) spi_bits(8'hFF, 8, d);
    cs_high();
    check("bad_op_cmd_err", err_cnt - err0, 1);
    check("bad_op_oe", oe_cnt - oe0, 0);
    check("bad_op_byte_wr", wr_cnt - wr0, 0);

    // Partial trailing byte is discarded on deselect.
    write_txn(24'h000006, 8'h77, 8'h00, 1);
    wr0 = wr_cnt;
    cs_low();
    header(8'h02, 24'h000005);
    spi_bits(8'hC3, 8, d);
    spi_bits(8'hF0, 4, d);
    #Half;
    bus.spi_cs_n = 1'b1;
    lat = 99;
    for (int i = 1; i <= 6; i++) begin
      #10;
      if (!busy && lat == 99) lat = i;
    end
    check("busy_fall_le3", (lat <= 3) ? 1 : 0, 1);
    #(4 * Half);
    check("partial_byte_wr", wr_cnt - wr0, 1);
    read2(24'h000005, r0, r1);
    check("rd_05", r0, 8'hC3);
    check("rd_06_untouched", r1, 8'h77);

    // Reset in the middle of a write data phase.
    write_txn(24'h000020, 8'h44, 8'h00, 1);
    wr0 = wr_cnt;
    cs_low();
    header(8'h02, 24'h000021);
    spi_bits(8'hEE, 5, d);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", bus.miso_oe, 0);
    check("mid_rst_miso", bus.spi_miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_byte_wr", byte_wr, 0);
    #29;
    rst_n = 1'b1;
    #40;
    bus.spi_cs_n = 1'b1;
    #(4 * Half);
    check("mid_rst_no_write", wr_cnt - wr0, 0);
    write_txn(24'h000021, 8'h99, 8'h00, 1);
    read2(24'h000020, r0, r1);
    check("post_rst_rd_20", r0, 8'h44);
    check("post_rst_rd_21", r1, 8'h99);

    // Upper address bits are ignored.
    read2(24'hFF0010, r0, r1);
    check("upper_addr_10", r0, 8'hA5);
    check("upper_addr_11", r1, 8'h5A);

    check("total_cmd_err", err_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
